// File: rtl/sd_spi_pkg.sv
// Shared constants and types for the SD-card SPI responder.
// Command indices, R1 flag bits, FSM state type, CRC7 polynomial.
package sd_spi_pkg;

  localparam logic [5:0] CMD0  = 6'd0;
  localparam logic [5:0] CMD8  = 6'd8;
  localparam logic [5:0] CMD41 = 6'd41;
  localparam logic [5:0] CMD55 = 6'd55;
  localparam logic [5:0] CMD58 = 6'd58;

  localparam logic [7:0] R1_IDLE    = 8'h01;
  localparam logic [7:0] R1_ILLEGAL = 8'h04;
  localparam logic [7:0] R1_CRC_ERR = 8'h08;

  // x^7 + x^3 + 1, x^7 term implicit
  localparam logic [6:0] CRC7_POLY = 7'h09;

  typedef enum logic [1:0] {
    IDLE,
    RX_CMD,
    NCR_WAIT,
    TX_RESP
  } state_t;

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 over command bits, one bit per i_en strobe.
// Ports: clk, rst_n, i_clr (sync clear), i_en, i_bit, o_crc[6:0].
import sd_spi_pkg::*;

module sd_crc7 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic       i_bit,
  output logic [6:0] o_crc
);

  logic [6:0] r_crc;
  logic       w_fb;

  assign w_fb  = i_bit ^ r_crc[6];
  assign o_crc = r_crc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc <= '0;
    end else if (i_clr) begin
      r_crc <= '0;
    end else if (i_en) begin
      r_crc <= {r_crc[5:0], 1'b0}
             ^ (w_fb ? CRC7_POLY : 7'h00);
    end
  end

endmodule

// File: rtl/sd_card_spi_responder.sv
// SD-card SPI-mode command responder (CMD0/8/55/ACMD41/58).
// Ports: clk210_p, reset_p, sd_spi_{sck,ss,mosi}_p in, sd_spi_miso_p,
// cmd_valid_p, cmd_index_p, cmd_arg_p, card_ready_p out.
import sd_spi_pkg::*;

module sd_card_spi_responder #(
  parameter int INIT_POLLS = 2,
  parameter bit CCS_BIT    = 1'b1,
  parameter bit CHECK_CRC  = 1'b0
) (
  input  logic        clk210_p,
  input  logic        reset_p,
  input  logic        sd_spi_sck_p,
  input  logic        sd_spi_ss_p,
  input  logic        sd_spi_mosi_p,
  output logic        sd_spi_miso_p,
  output logic        cmd_valid_p,
  output logic [5:0]  cmd_index_p,
  output logic [31:0] cmd_arg_p,
  output logic        card_ready_p
);

  localparam logic [7:0] LP_POLLS = 8'(INIT_POLLS);

  logic [1:0]  r_sck_s, r_ss_s, r_mosi_s;
  logic        r_sck_d;
  state_t      r_state, w_state_nx;
  logic        r_got0;
  logic [5:0]  r_bcnt;
  logic [44:0] r_sh;
  logic [39:0] r_resp;
  logic [5:0]  r_len;
  logic        r_miso, r_valid;
  logic [5:0]  r_idx;
  logic [31:0] r_arg;
  logic        r_ready, r_app;
  logic [7:0]  r_cnt;

  logic        w_sck, w_ss, w_mosi;
  logic        w_rise, w_fall, w_end;
  logic [5:0]  w_idx;
  logic [31:0] w_arg;
  logic [6:0]  w_crc_rx, w_crc;
  logic        w_crc_ok, w_idle;
  logic [39:0] w_resp;
  logic [5:0]  w_len;
  logic        w_rdy_nx, w_app_nx;
  logic [7:0]  w_cnt_nx;

  assign w_sck  = r_sck_s[1];
  assign w_ss   = r_ss_s[1];
  assign w_mosi = r_mosi_s[1];
  assign w_rise = w_sck & ~r_sck_d;
  assign w_fall = ~w_sck & r_sck_d;

  // index, arg, crc survive in r_sh; start/tx bits shift out the top
  assign w_idx    = r_sh[44:39];
  assign w_arg    = r_sh[38:7];
  assign w_crc_rx = r_sh[6:0];
  assign w_end    = (r_state == RX_CMD) & w_rise
                  & (r_bcnt == 6'd47);
  assign w_idle   = ~r_ready;

  generate
    if (CHECK_CRC) begin : g_crc
      logic w_clr, w_en;
      // a lone '0' from a cleared CRC leaves it at zero,
      // so clearing on every IDLE zero primes the start bit
      assign w_clr = ~w_ss & w_rise & ~w_mosi
                   & (r_state == IDLE);
      assign w_en  = ~w_ss & w_rise
                   & (((r_state == IDLE) & w_mosi & r_got0)
                   | ((r_state == RX_CMD) & (r_bcnt < 6'd40)));
      sd_crc7 u_crc (
        .clk   (clk210_p),
        .rst_n (reset_p),
        .i_clr (w_clr),
        .i_en  (w_en),
        .i_bit (w_mosi),
        .o_crc (w_crc)
      );
    end else begin : g_no_crc
      assign w_crc = '0;
    end
  endgenerate

  assign w_crc_ok = !CHECK_CRC || (w_crc == w_crc_rx);

  always_comb begin
    w_rdy_nx = r_ready;
    w_app_nx = 1'b0;
    w_cnt_nx = r_cnt;
    w_resp   = '0;
    w_len    = 6'd8;
    if (!w_crc_ok) begin
      w_app_nx     = r_app;
      w_resp[39:32] = R1_CRC_ERR | {7'b0, w_idle};
    end else begin
      unique case (1'b1)
        (w_idx == CMD0): begin
          w_rdy_nx      = 1'b0;
          w_cnt_nx      = '0;
          w_resp[39:32] = R1_IDLE;
        end
        (w_idx == CMD8): begin
          w_resp = {7'b0, w_idle, 16'h0000,
                    4'h0, w_arg[11:0]};
          w_len  = 6'd40;
        end
        (w_idx == CMD55): begin
          w_app_nx      = 1'b1;
          w_resp[39:32] = {7'b0, w_idle};
        end
        ((w_idx == CMD41) && r_app): begin
          if (r_cnt < LP_POLLS) begin
            w_cnt_nx      = r_cnt + 8'd1;
            w_resp[39:32] = R1_IDLE;
          end else begin
            w_rdy_nx = 1'b1;
          end
        end
        (w_idx == CMD58): begin
          w_resp = {7'b0, w_idle, r_ready,
                    r_ready & CCS_BIT, 6'b0,
                    24'hFF8000};
          w_len  = 6'd40;
        end
        default: begin
          w_resp[39:32] = R1_ILLEGAL | {7'b0, w_idle};
        end
      endcase
    end
  end

  always_comb begin
    w_state_nx = r_state;
    if (w_ss) begin
      w_state_nx = IDLE;
    end else begin
      unique case (r_state)
        IDLE:
          if (w_rise && w_mosi && r_got0)
            w_state_nx = RX_CMD;
        RX_CMD:
          if (w_end)
            w_state_nx = w_mosi ? NCR_WAIT : IDLE;
        NCR_WAIT:
          if (w_fall && r_bcnt == 6'd8)
            w_state_nx = TX_RESP;
        TX_RESP:
          if (w_fall && r_bcnt == r_len)
            w_state_nx = IDLE;
        default: w_state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk210_p or negedge reset_p) begin
    if (!reset_p) r_state <= IDLE;
    else          r_state <= w_state_nx;
  end

  always_ff @(posedge clk210_p or negedge reset_p) begin
    if (!reset_p) begin
      r_sck_s  <= 2'b00;
      r_ss_s   <= 2'b11;
      r_mosi_s <= 2'b11;
      r_sck_d  <= 1'b0;
      r_got0   <= 1'b0;
      r_bcnt   <= '0;
      r_sh     <= '0;
      r_resp   <= '0;
      r_len    <= 6'd8;
      r_miso   <= 1'b1;
      r_valid  <= 1'b0;
      r_idx    <= '0;
      r_arg    <= '0;
      r_ready  <= 1'b0;
      r_app    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sck_s  <= {r_sck_s[0], sd_spi_sck_p};
      r_ss_s   <= {r_ss_s[0], sd_spi_ss_p};
      r_mosi_s <= {r_mosi_s[0], sd_spi_mosi_p};
      r_sck_d  <= w_sck;
      r_valid  <= 1'b0;
      if (w_ss) begin
        r_miso <= 1'b1;
        r_bcnt <= '0;
        r_got0 <= 1'b0;
      end else begin
        unique case (r_state)
          IDLE: begin
            r_miso <= 1'b1;
            if (w_rise) begin
              r_got0 <= ~w_mosi;
              r_bcnt <= 6'd2;
              r_sh   <= '0;
            end
          end
          RX_CMD: if (w_rise) begin
            r_sh   <= {r_sh[43:0], w_mosi};
            r_bcnt <= r_bcnt + 6'd1;
            if (w_end) begin
              r_bcnt <= '0;
              if (w_mosi) begin
                r_valid <= 1'b1;
                r_idx   <= w_idx;
                r_arg   <= w_arg;
                r_resp  <= w_resp;
                r_len   <= w_len;
                r_ready <= w_rdy_nx;
                r_app   <= w_app_nx;
                r_cnt   <= w_cnt_nx;
              end
            end
          end
          // ninth falling edge after the end bit drives the first
          // response bit, so the host reads one full 0xFF first
          NCR_WAIT: if (w_fall) begin
            if (r_bcnt == 6'd8) begin
              r_miso <= r_resp[39];
              r_resp <= {r_resp[38:0], 1'b0};
              r_bcnt <= 6'd1;
            end else begin
              r_bcnt <= r_bcnt + 6'd1;
            end
          end
          TX_RESP: if (w_fall) begin
            if (r_bcnt == r_len) begin
              r_miso <= 1'b1;
            end else begin
              r_miso <= r_resp[39];
              r_resp <= {r_resp[38:0], 1'b0};
              r_bcnt <= r_bcnt + 6'd1;
            end
          end
          default: r_miso <= 1'b1;
        endcase
      end
    end
  end

  assign sd_spi_miso_p = r_miso;
  assign cmd_valid_p   = r_valid;
  assign cmd_index_p   = r_idx;
  assign cmd_arg_p     = r_arg;
  assign card_ready_p  = r_ready;

endmodule

// File: tb/tb_sd_card_spi_responder.sv
// Directed bench for sd_card_spi_responder over SPI mode 0.
// Drives command frames and checks MISO bytes and status outputs.
module tb_sd_card_spi_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sck = 1'b0;
  logic        ss = 1'b1;
  logic        mosi = 1'b1;
  logic        miso;
  logic        cmd_valid;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        card_ready;

  int n_vec = 0;
  int n_err = 0;
  int n_valid = 0;

  always #5 clk = ~clk;

  sd_card_spi_responder #(
    .INIT_POLLS (2),
    .CCS_BIT    (1'b1),
    .CHECK_CRC  (1'b1)
  ) dut (
    .clk210_p      (clk),
    .reset_p       (rst_n),
    .sd_spi_sck_p  (sck),
    .sd_spi_ss_p   (ss),
    .sd_spi_mosi_p (mosi),
    .sd_spi_miso_p (miso),
    .cmd_valid_p   (cmd_valid),
    .cmd_index_p   (cmd_index),
    .cmd_arg_p     (cmd_arg),
    .card_ready_p  (card_ready)
  );

  always @(negedge clk)
    if (cmd_valid) n_valid++;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [7:0] crc_byte(
      input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] m;
    logic [6:0]  c;
    logic        fb;
    m = {2'b01, idx, arg};
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = m[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return {c, 1'b1};
  endfunction

  task automatic xbit(input logic b, output logic r);
    mosi = b;
    #40 sck = 1'b1;
    r = miso;
    #40 sck = 1'b0;
  endtask

  task automatic xbyte(input logic [7:0] b,
                       output logic [7:0] r);
    logic t;
    for (int i = 7; i >= 0; i--) begin
      xbit(b[i], t);
      r[i] = t;
    end
  endtask

  task automatic send_frame(input logic [5:0] idx,
                            input logic [31:0] arg,
                            input logic [7:0] crcb);
    logic [47:0] f;
    logic [7:0]  d;
    f = {2'b01, idx, arg, crcb};
    for (int i = 5; i >= 0; i--)
      xbyte(f[i*8 +: 8], d);
  endtask

  task automatic do_cmd(input logic [5:0] idx,
                        input logic [31:0] arg,
                        input logic [7:0] crcb,
                        input int nb,
                        output logic [7:0] ncr,
                        output logic [39:0] resp);
    logic [7:0] d;
    ss = 1'b0;
    #80;
    xbyte(8'hFF, d);
    send_frame(idx, arg, crcb);
    xbyte(8'hFF, ncr);
    resp = '0;
    for (int i = 0; i < nb; i++) begin
      xbyte(8'hFF, d);
      resp = {resp[31:0], d};
    end
    #160 ss = 1'b1;
    #160;
  endtask

  task automatic cmd_chk(input string tag,
                         input logic [5:0] idx,
                         input logic [31:0] arg,
                         input logic [7:0] crcb,
                         input int nb,
                         input logic [39:0] exp);
    logic [7:0]  ncr;
    logic [39:0] resp;
    int          v0;
    v0 = n_valid;
    do_cmd(idx, arg, crcb, nb, ncr, resp);
    chk({tag, "_ncr"}, 64'(ncr), 64'hFF);
    chk({tag, "_resp"}, 64'(resp), 64'(exp));
    chk({tag, "_vld"}, 64'(n_valid - v0), 64'd1);
    chk({tag, "_idx"}, 64'(cmd_index), 64'(idx));
  endtask

  initial begin
    logic [7:0]  d;
    logic [47:0] f;
    logic        t;
    int          v0;

    repeat (3) @(negedge clk);
    chk("rst_miso", 64'(miso), 64'd1);
    chk("rst_valid", 64'(cmd_valid), 64'd0);
    chk("rst_idx", 64'(cmd_index), 64'd0);
    chk("rst_arg", 64'(cmd_arg), 64'd0);
    chk("rst_ready", 64'(card_ready), 64'd0);
    rst_n = 1'b1;
    #100;

    cmd_chk("cmd0", 6'd0, 32'h0, 8'h95, 1, 40'h01);
    cmd_chk("cmd8", 6'd8, 32'h1AA, 8'h87, 5,
            40'h01_00_00_01_AA);
    chk("cmd8_arg", 64'(cmd_arg), 64'h1AA);
    cmd_chk("cmd58_busy", 6'd58, 32'h0, 8'hFD, 5,
            40'h01_00_FF_80_00);

    cmd_chk("cmd55_a", 6'd55, 32'h0, 8'h65, 1, 40'h01);
    cmd_chk("acmd41_a", 6'd41, 32'h40000000, 8'h77, 1,
            40'h01);
    chk("acmd41_arg", 64'(cmd_arg), 64'h40000000);
    chk("ready_a", 64'(card_ready), 64'd0);
    cmd_chk("cmd55_b", 6'd55, 32'h0, 8'h65, 1, 40'h01);
    cmd_chk("acmd41_b", 6'd41, 32'h40000000, 8'h77, 1,
            40'h01);
    chk("ready_b", 64'(card_ready), 64'd0);
    cmd_chk("cmd55_c", 6'd55, 32'h0, 8'h65, 1, 40'h01);
    cmd_chk("acmd41_c", 6'd41, 32'h40000000, 8'h77, 1,
            40'h00);
    chk("ready_c", 64'(card_ready), 64'd1);

    cmd_chk("cmd58_rdy", 6'd58, 32'h0, 8'hFD, 5,
            40'h00_C0_FF_80_00);
    cmd_chk("cmd41_noapp", 6'd41, 32'h40000000, 8'h77, 1,
            40'h04);

    // corrupted CRC on CMD55: error flag, app flag left clear
    begin
      logic [39:0] resp;
      logic [7:0]  ncr;
      do_cmd(6'd55, 32'h0, 8'h67, 1, ncr, resp);
      chk("badcrc_resp", 64'(resp), 64'h08);
    end
    cmd_chk("cmd41_after_bad", 6'd41, 32'h40000000, 8'h77,
            1, 40'h04);

    // reset in the middle of the CMD58 OCR byte (0xC0)
    ss = 1'b0;
    #80;
    send_frame(6'd58, 32'h0, 8'hFD);
    xbyte(8'hFF, d);
    chk("rst_tx_ncr", 64'(d), 64'hFF);
    xbyte(8'hFF, d);
    chk("rst_tx_r1", 64'(d), 64'h00);
    for (int i = 0; i < 4; i++) xbit(1'b1, t);
    #40;
    chk("pre_rst_miso", 64'(miso), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_miso", 64'(miso), 64'd1);
    chk("mid_rst_ready", 64'(card_ready), 64'd0);
    chk("mid_rst_idx", 64'(cmd_index), 64'd0);
    #19 ss = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #200;

    cmd_chk("unk3f", 6'h3F, 32'h0,
            crc_byte(6'h3F, 32'h0), 1, 40'h05);

    // abort after 20 bits of CMD8
    v0 = n_valid;
    f  = {8'h48, 32'h1AA, 8'h87};
    ss = 1'b0;
    #80;
    for (int i = 47; i >= 28; i--) xbit(f[i], t);
    #40 ss = 1'b1;
    #200;
    chk("abort_vld", 64'(n_valid - v0), 64'd0);
    chk("abort_miso", 64'(miso), 64'd1);
    chk("abort_idx", 64'(cmd_index), 64'h3F);
    cmd_chk("cmd0_after", 6'd0, 32'h0, 8'h95, 1, 40'h01);
    chk("final_ready", 64'(card_ready), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sd_card_spi_responder.md
SD_CARD_SPI_RESPONDER -- requirements
Module: sd_card_spi_responder

Interface
REQ-001 Parameter INIT_POLLS, default 2: number of ACMD41 commands answered "busy" (R1=0x01) before the card reports ready (R1=0x00).
REQ-002 Parameter CCS_BIT, default 1: value reported in OCR bit 30 once the card is ready.
REQ-003 Parameter CHECK_CRC, default 0: when 1, a CRC7 mismatch on any command returns R1=0x08 (plus the idle bit if idle) and the command is not executed.
REQ-004 clk210_p  input  1  single system clock; all logic is in this domain.
REQ-005 reset_p  input  1  asynchronous, active-low reset.
REQ-006 sd_spi_sck_p  input  1  SPI clock from the host, mode 0.
REQ-007 sd_spi_ss_p  input  1  chip select from the host, active-low.
REQ-008 sd_spi_mosi_p  input  1  command data from the host.
REQ-009 sd_spi_miso_p  output  1  response data to the host.
REQ-010 cmd_valid_p  output  1  one-cycle pulse when a command frame has been accepted.
REQ-011 cmd_index_p  output  6  index of the last accepted command.
REQ-012 cmd_arg_p  output  32  argument of the last accepted command.
REQ-013 card_ready_p  output  1  high once initialization has completed (ACMD41 returned 0x00).

Function
REQ-014 sck, ss and mosi SHALL pass through 2-flop synchronizers; sck edges are detected in the clk210_p domain; supported SCK frequency is at most clk210/8.
REQ-015 MOSI SHALL be sampled on SCK rising edges; MISO SHALL change only on SCK falling edges; bits are MSB first.
REQ-016 While ss is high, the FSM SHALL be held in IDLE with MISO=1, and the bit counters are cleared.
REQ-017 FSM states: IDLE, RX_CMD, NCR_WAIT, TX_RESP.
REQ-018 IDLE -> RX_CMD: ss low and a sampled bit pattern '0' followed by '1' (start bit and transmission bit); all leading '1' bits are ignored.
REQ-019 RX_CMD shifts in a 48-bit frame: start(1), tx(1), index(6), argument(32), crc7(7), end(1).
REQ-020 If the end bit is 0, the frame SHALL be dropped silently and the FSM returns to IDLE.
REQ-021 On a valid frame: update cmd_index_p/cmd_arg_p, pulse cmd_valid_p for 1 clk210 cycle, go to NCR_WAIT.
REQ-022 NCR_WAIT drives MISO=1 for exactly 8 SCK cycles (one 0xFF byte), then goes to TX_RESP.
REQ-023 Response table (idle = not card_ready):
- CMD0: R1=0x01; clears ready and the ACMD41 counter.
- CMD8: R7 = R1, then 0x00, 0x00, arg[11:8], arg[7:0] (echo of VHS and check pattern).
- CMD55: R1; sets the app flag.
- ACMD41 (CMD41 with app flag set): R1=0x01 while the counter is below INIT_POLLS, and the counter increments; afterwards R1=0x00 and card_ready_p is set.
- CMD58: R3 = R1, then OCR = {ready, ready&CCS_BIT, 6'b0, 24'hFF8000}.
- CMD41 without app flag, and any other index: R1 = 0x04 | idle.
REQ-024 The app flag SHALL clear after any command other than CMD55.
REQ-025 TX_RESP shifts out 8 bits (R1) or 40 bits (R3/R7), then returns to IDLE with MISO=1.
REQ-026 MOSI bits received during NCR_WAIT/TX_RESP SHALL be ignored; no new command is detected until the FSM is back in IDLE.
REQ-027 If ss deasserts mid-frame or mid-response, the FSM SHALL abort to IDLE, no cmd_valid_p is generated for an unfinished frame, and card_ready_p, the app flag and the ACMD41 counter are retained.
REQ-028 A cmd_valid_p pulse SHALL occur within 4 clk210 cycles of the SCK rising edge that samples the end bit.
REQ-029 The ACMD41 counter SHALL saturate at INIT_POLLS and never wrap.

Reset
REQ-030 While reset_p=0: FSM=IDLE, sd_spi_miso_p=1, cmd_valid_p=0, cmd_index_p=0, cmd_arg_p=0, card_ready_p=0, app flag=0, ACMD41 counter=0, and the synchronizers are preset to sck=0, ss=1, mosi=1.
REQ-031 Release of reset SHALL take effect on the next clk210_p edge; no response starts without a fresh start-bit detection.

Structure
REQ-032 Package sd_spi_pkg SHALL hold: command index constants (CMD0, CMD8, CMD41, CMD55, CMD58), R1 bit constants, the FSM state typedef, and the CRC7 polynomial.
REQ-033 One sub-module, sd_crc7, SHALL implement the serial CRC7 (x^7+x^3+1), clocked per received bit; it is instantiated only when CHECK_CRC=1.

Verification
REQ-034 CMD0 frame 0x40_00000000_95 -> 0xFF, then 0x01 on MISO; cmd_valid_p pulses once with cmd_index_p=0.
REQ-035 CMD8 with argument 0x000001AA -> 0x01 00 00 01 AA.
REQ-036 With INIT_POLLS=2: sequence (CMD55, ACMD41 0x40000000) x3 -> R1 values 0x01, 0x01, 0x00; card_ready_p rises after the third.
REQ-037 CMD58 after ready with CCS_BIT=1 -> 0x00 C0 FF 80 00; CMD58 before ready -> 0x01 00 FF 80 00.
REQ-038 ss deasserted after 20 bits of a CMD8 -> no cmd_valid_p, MISO=1; a following full CMD0 is answered 0x01.
REQ-039 Assert reset_p low during TX_RESP -> MISO=1 immediately and card_ready_p=0; CMD99-style unknown index 0x3F -> R1=0x05.
